// File: rtl/lsu_ctrl.sv
// Load/store unit: one RISC-V load/store at a time over a word-addressed memory port.
// Handles lane selection, sign/zero extension, and splits word-crossing accesses in two.
module lsu_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        err_q, err_d;

    logic        req_f3_bad, req_mis, req_bad;
    logic [1:0]  off;
    logic [3:0]  nmask;
    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [31:0] word_base;
    logic [31:0] wr_raw;
    logic [31:0] load_shift;
    logic [31:0] load_ext;

    // Legality is judged on the live request so an illegal one skips memory entirely.
    always_comb begin
        if (req_store)
            req_f3_bad = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            req_f3_bad = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & req_funct3[1]);
        req_mis = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        req_bad = req_f3_bad | (!ALLOW_MISALIGNED & req_mis);
    end

    assign off       = addr_q[1:0];
    assign nmask     = (funct3_q[1:0] == 2'b00) ? 4'b0001 :
                       (funct3_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign mask8     = {4'b0000, nmask} << off;
    assign wide      = {32'b0, wdata_q} << {off, 3'b000};
    assign word_base = {addr_q[31:2], 2'b00};

    // Memory port is decoded purely from the state register, so reset kills writes at once.
    always_comb begin
        daddr  = 32'h0;
        dwe    = 4'b0000;
        wr_raw = 32'h0;
        case (state_q)
            ACC0: begin
                daddr  = word_base;
                dwe    = store_q ? mask8[3:0] : 4'b0000;
                wr_raw = wide[31:0];
            end
            ACC1: begin
                daddr  = word_base + 32'd4;
                dwe    = store_q ? mask8[7:4] : 4'b0000;
                wr_raw = wide[63:32];
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign dwdata[8*gi +: 8] = dwe[gi] ? wr_raw[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign load_shift = 32'({hi_q, lo_q} >> {off, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {24'h0, load_shift[7:0]};
            3'b101:  load_ext = {16'h0, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_err   = (state_q == DONE) & err_q;
    assign resp_rdata = ((state_q == DONE) & !store_q & !err_q) ? load_ext : 32'h0;

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                store_d  = req_store;
                funct3_d = req_funct3;
                addr_d   = req_addr;
                wdata_d  = req_wdata;
                lo_d     = 32'h0;
                hi_d     = 32'h0;
                err_d    = req_bad;
                state_d  = req_bad ? DONE : ACC0;
            end
            ACC0: begin
                if (!store_q) lo_d = drdata;
                state_d = (mask8[7:4] != 4'b0000) ? ACC1 : DONE;
            end
            ACC1: begin
                if (!store_q) hi_d = drdata;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            lo_q     <= 32'h0;
            hi_q     <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-addressed reference memory model, directed cases, random traffic,
// plus a second instance with misaligned accesses disallowed.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, daddr, dwdata, drdata;
    logic [3:0]  dwe;

    logic        m_req_valid = 1'b0, m_req_ready, m_req_store = 1'b0;
    logic [2:0]  m_req_funct3 = 3'b0;
    logic [31:0] m_req_addr = 32'h0, m_req_wdata = 32'h0;
    logic        m_resp_valid, m_resp_err;
    logic [31:0] m_resp_rdata, m_daddr, m_dwdata;
    logic [31:0] m_drdata = 32'h80FF7F01;
    logic [3:0]  m_dwe;

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
    );

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_m (
        .clk(clk), .reset(rst), .req_valid(m_req_valid), .req_ready(m_req_ready),
        .req_store(m_req_store), .req_funct3(m_req_funct3), .req_addr(m_req_addr),
        .req_wdata(m_req_wdata), .resp_valid(m_resp_valid), .resp_rdata(m_resp_rdata),
        .resp_err(m_resp_err), .daddr(m_daddr), .dwdata(m_dwdata), .dwe(m_dwe), .drdata(m_drdata)
    );

    // Memory seen by the DUT (1 KiB, address aliased on bits [9:0]) and the reference copy.
    logic [7:0] mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (dwe[i]) mem[{daddr[9:2], 2'(i)}] <= dwdata[8*i +: 8];
        end
    end
    assign drdata = {mem[{daddr[9:2], 2'd3}], mem[{daddr[9:2], 2'd2}],
                     mem[{daddr[9:2], 2'd1}], mem[{daddr[9:2], 2'd0}]};

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results of the latest transaction, for directed checks.
    logic [31:0] last_rd;
    logic [31:0] wr_addr [2];
    logic [3:0]  wr_dwe  [2];
    logic [31:0] wr_data [2];

    // Reference behaviour: byte-wise access to ref_mem at addr..addr+n-1 (32-bit wrap).
    task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
        int unsigned n;
        bit          legal;
        int          exp_lat, exp_nwr, got_lat, nwr;
        logic [31:0] exp_rd, v;
        logic        got_err, lanebad;
        logic [31:0] got_rd;
        n = 1 << f3[1:0];
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_rd = 32'h0;
        exp_nwr = 0;
        if (!legal) begin
            exp_lat = 1;
        end else begin
            exp_lat = ((addr % 4) + n > 4) ? 3 : 2;
            if (st) begin
                exp_nwr = exp_lat - 1;
                for (int i = 0; i < int'(n); i++) ref_mem[10'(addr + 32'(i))] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < int'(n); i++) v[8*i +: 8] = ref_mem[10'(addr + 32'(i))];
                if (f3 == 3'd0)      exp_rd = {{24{v[7]}}, v[7:0]};
                else if (f3 == 3'd1) exp_rd = {{16{v[15]}}, v[15:0]};
                else                 exp_rd = v;
            end
        end

        @(negedge clk);
        chk("ready", {31'b0, req_ready}, 32'd1);
        chk("pulse", {31'b0, resp_valid}, 32'd0);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = $urandom_range(0, 1); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        got_lat = 0; nwr = 0; lanebad = 1'b0; got_err = 1'b0; got_rd = 32'h0;
        for (int k = 1; k <= 6 && got_lat == 0; k++) begin
            @(negedge clk);
            if (dwe != 4'b0) begin
                if (nwr < 2) begin
                    wr_addr[nwr] = daddr; wr_dwe[nwr] = dwe; wr_data[nwr] = dwdata;
                end
                nwr++;
            end
            for (int i = 0; i < 4; i++)
                if (!dwe[i] && dwdata[8*i +: 8] != 8'h00) lanebad = 1'b1;
            if (daddr[1:0] != 2'b00) lanebad = 1'b1;
            if (resp_valid) begin
                got_lat = k; got_err = resp_err; got_rd = resp_rdata;
            end
        end
        last_rd = got_rd;
        n_txn++;
        $display("[TB] txn %0d %s f3=%0d addr=%08h wd=%08h -> lat=%0d err=%0b rd=%08h (exp lat=%0d err=%0b rd=%08h)",
                 n_txn, st ? "ST" : "LD", f3, addr, wd, got_lat, got_err, got_rd,
                 exp_lat, !legal, exp_rd);
        chk("latency", 32'(got_lat), 32'(exp_lat));
        chk("err", {31'b0, got_err}, {31'b0, !legal});
        chk("rdata", got_rd, exp_rd);
        chk("writes", 32'(nwr), 32'(exp_nwr));
        chk("lanes", {31'b0, lanebad}, 32'd0);
    endtask

    task automatic run_m(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input bit exp_err, input logic [31:0] exp_rd);
        int   got_lat;
        logic anywr, got_err;
        logic [31:0] got_rd;
        @(negedge clk);
        m_req_valid = 1'b1; m_req_store = st; m_req_funct3 = f3; m_req_addr = addr;
        m_req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 m_req_valid = 1'b0;
        got_lat = 0; anywr = 1'b0; got_err = 1'b0; got_rd = 32'h0;
        for (int k = 1; k <= 6 && got_lat == 0; k++) begin
            @(negedge clk);
            if (m_dwe != 4'b0) anywr = 1'b1;
            if (m_resp_valid) begin
                got_lat = k; got_err = m_resp_err; got_rd = m_resp_rdata;
            end
        end
        n_txn++;
        $display("[TB] txn %0d strict %s f3=%0d addr=%08h -> lat=%0d err=%0b rd=%08h",
                 n_txn, st ? "ST" : "LD", f3, addr, got_lat, got_err, got_rd);
        chk("m_latency", 32'(got_lat), exp_err ? 32'd1 : 32'd2);
        chk("m_err", {31'b0, got_err}, {31'b0, exp_err});
        chk("m_rdata", got_rd, exp_rd);
        if (exp_err || !st) chk("m_nowrite", {31'b0, anywr}, 32'd0);
    endtask

    initial begin
        logic [31:0] pre;
        logic [31:0] ra;
        logic [2:0]  rf;
        int          r;
        int          bad;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_dwe", {28'b0, dwe}, 32'h0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_dwdata", dwdata, 32'h0);
        rst = 1'b0; mem_clr = 1'b0;

        run(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        chk("sw_addr", wr_addr[0], 32'h100);
        chk("sw_dwe", {28'b0, wr_dwe[0]}, 32'hF);
        run(1'b0, 3'd2, 32'h100, 32'h0);
        chk("lw_100", last_rd, 32'hDEADBEEF);

        run(1'b1, 3'd2, 32'h200, 32'h80FF7F01);
        run(1'b0, 3'd0, 32'h202, 32'h0); chk("lb_202", last_rd, 32'hFFFFFFFF);
        run(1'b0, 3'd4, 32'h203, 32'h0); chk("lbu_203", last_rd, 32'h00000080);
        run(1'b0, 3'd1, 32'h202, 32'h0); chk("lh_202", last_rd, 32'hFFFF80FF);
        run(1'b0, 3'd5, 32'h200, 32'h0); chk("lhu_200", last_rd, 32'h00007F01);

        run(1'b1, 3'd2, 32'h103, 32'h11223344);
        chk("split_a0", wr_addr[0], 32'h100);
        chk("split_e0", {28'b0, wr_dwe[0]}, 32'h8);
        chk("split_d0", wr_data[0], 32'h44000000);
        chk("split_a1", wr_addr[1], 32'h104);
        chk("split_e1", {28'b0, wr_dwe[1]}, 32'h7);
        chk("split_d1", wr_data[1], 32'h00112233);
        run(1'b0, 3'd2, 32'h103, 32'h0); chk("lw_103", last_rd, 32'h11223344);

        run(1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000ABCD);
        chk("wrap_a0", wr_addr[0], 32'hFFFFFFFC);
        chk("wrap_e0", {28'b0, wr_dwe[0]}, 32'h8);
        chk("wrap_a1", wr_addr[1], 32'h00000000);
        chk("wrap_e1", {28'b0, wr_dwe[1]}, 32'h1);

        run(1'b1, 3'd4, 32'h120, 32'h12345678);
        run(1'b0, 3'd7, 32'h120, 32'h0);

        run_m(1'b0, 3'd2, 32'h102, 1'b1, 32'h0);
        run_m(1'b1, 3'd1, 32'h201, 1'b1, 32'h0);
        run_m(1'b1, 3'd2, 32'h101, 1'b1, 32'h0);
        run_m(1'b0, 3'd1, 32'h202, 1'b0, 32'hFFFF80FF);
        run_m(1'b0, 3'd4, 32'h203, 1'b0, 32'h00000080);

        // Reset asserted during ACC0 of a store: the write must never happen.
        pre = {ref_mem[10'h303], ref_mem[10'h302], ref_mem[10'h301], ref_mem[10'h300]};
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h300; req_wdata = 32'h55AA55AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_dwe", {28'b0, dwe}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst_mem", {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]}, pre);
        n_txn++;
        $display("[TB] txn %0d reset during SW @300, word now %08h", n_txn,
                 {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]});

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 5: rf = 3'd0;
                1, 6: rf = 3'd1;
                2, 7: rf = 3'd2;
                3:    rf = 3'd4;
                4:    rf = 3'd5;
                default: rf = 3'($urandom);
            endcase
            ra = {22'h0, 10'($urandom)};
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFC00 | ra;
            run(1'($urandom_range(0, 1)), rf, ra, $urandom);
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting between the CPU execute stage and the byte-banked data memory. Accepts one RISC-V load/store request at a time, drives the word-addressed memory port (daddr/dwdata/dwe, combinational-read drdata), performs all byte-lane selection, shifting and sign/zero extension, and splits accesses that cross a 32-bit word boundary into two sequential word accesses. Returns one completion per request.

## Interface
- ALLOW_MISALIGNED, 1, 1: word-crossing accesses are split into two accesses; 0: any misaligned access is rejected with resp_err
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  illegal funct3, or misaligned access with ALLOW_MISALIGNED=0; valid with resp_valid
- daddr  out  32  memory byte address, always word-aligned (bits [1:0] = 0)
- dwdata  out  32  lane-positioned write data
- dwe  out  4  per-byte write enables, bit i = byte lane i
- drdata  in  32  memory read word, combinational from daddr

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: req_ready=1. Handshake on req_valid & req_ready at a rising edge: register store, funct3, addr, wdata. Go to DONE with error if illegal (store funct3 ∉ {000,001,010}; load funct3 ∈ {011,110,111}; misaligned with ALLOW_MISALIGNED=0). Otherwise go to ACC0.
- Size n = 1/2/4 bytes, offset o = addr[1:0]. mask8 = ((1<<n)-1) << o (8 bits). wide = {32'b0, wdata} << (8*o) (64 bits). Misaligned means o is not a multiple of n.
- ACC0: daddr = {addr[31:2],2'b00}. For stores, dwe = mask8[3:0] and dwdata = wide[31:0]. For loads, dwe = 0 and drdata is captured into lo. Next state is ACC1 if mask8[7:4] != 0, else DONE.
- ACC1: daddr = {addr[31:2],2'b00} + 4. The 32-bit sum wraps, so 0xFFFFFFFC goes to 0x00000000. For stores, dwe = mask8[7:4] and dwdata = wide[63:32]. For loads, drdata is captured into hi. Next state is DONE.
- DONE: resp_valid=1 for exactly one cycle. For loads, resp_rdata = ({hi,lo} >> 8*o) truncated to n bytes, then sign-extended (B/H) or zero-extended (BU/HU/W). hi is treated as 0 if ACC1 was skipped. Next state is IDLE.
- Outside ACC0/ACC1, dwe = 0, daddr = 0 and dwdata = 0. dwe is decoded from the state register so no stray write ever reaches memory.
- In ACC states, lanes with dwe=0 carry 0 in dwdata.

## Timing
- Reset (asynchronous, immediate): state=IDLE. Output values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dwe=0, daddr=0, dwdata=0. lo, hi and the request registers are cleared.
- Reset during ACC0/ACC1 deasserts dwe in the same cycle, so no write occurs at the next edge. Any partially written misaligned store is left as is and not rolled back.
- Aligned access latency: accept at edge E, ACC0 during E..E+1, resp_valid during E+1..E+2. A new request can be accepted at E+3.
- Word-crossing access latency: resp_valid one cycle later than aligned.
- Error latency: resp_valid during the cycle right after accept. There is no memory access.
- req_valid while not in IDLE is ignored. The requester holds the request until req_ready is seen.
- Memory writes occur on the rising edge that ends ACC0/ACC1. Load data is sampled on that same edge.

## Test plan
- Aligned LW/SW: SW 0xDEADBEEF @0x100, then LW @0x100. Required: one write cycle with dwe=1111, daddr=0x100; rdata=0xDEADBEEF; resp_valid two cycles after each accept.
- Byte/half extension: memory word @0x200 = 0x80FF7F01. Required:
  - LB @0x202 → 0xFFFFFFFF
  - LBU @0x203 → 0x00000080
  - LH @0x202 → 0xFFFF80FF
  - LHU @0x200 → 0x00007F01
- Split store/load: SW 0x11223344 @0x103. Required: ACC0 daddr=0x100, dwe=1000, dwdata=0x44000000; ACC1 daddr=0x104, dwe=0111, dwdata=0x00112233. A following LW @0x103 returns 0x11223344 with 3-cycle latency.
- Wrap: SH 0xABCD @0xFFFFFFFF with ALLOW_MISALIGNED=1. Required: ACC0 daddr=0xFFFFFFFC dwe=1000; ACC1 daddr=0x00000000 dwe=0001.
- Errors: each of the following gives resp_err=1, rdata=0, and dwe stays 0 throughout:
  - store funct3=100
  - load funct3=111
  - LW @0x102 with ALLOW_MISALIGNED=0
- Reset mid-op: assert reset during ACC0 of SW @0x300. Required: dwe=0 in that cycle, word @0x300 unchanged, req_ready=1 after reset releases.
